// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE754 single divider, radix-2 restoring, one quotient bit per clock.
// Optional status flags {invalid, divzero, overflow, underflow} when FP_DIV_FLAGS_EN is defined.
module fp_div_seq #(
  parameter int          QBITS       = 26,
  parameter logic [31:0] NAN_PATTERN = 32'h7FFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
`ifdef FP_DIV_FLAGS_EN
  output logic [3:0]  flags,
`endif
  output logic [31:0] result
);
  typedef enum logic [2:0] {IDLE, SPEC, DIV, NORM, DONE} state_t;
  state_t             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d, sign_q, sign_d;
  logic        [31:0] result_q, result_d, pend_q, pend_d, a_q, a_d, b_q, b_d;
  logic        [24:0] rem_q, rem_d, diff, rsel;
  logic        [23:0] dvs_q, dvs_d;
  logic        [25:0] q_q, q_d;
  logic signed [9:0]  exp_q, exp_d, en;
  logic        [4:0]  cnt_q, cnt_d;
  logic        [22:0] frac;
  logic               ge, nan_s, inf_s, dz_s, ovf, unf;
  function automatic logic is_nan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 23'h0;
  endfunction
  function automatic logic is_inf(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] == 23'h0;
  endfunction
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction
  function automatic logic is_spec(input logic [31:0] x);
    return x[30:23] == 8'hFF || x[30:23] == 8'h00;
  endfunction
  assign nan_s = is_nan(a_q) || is_nan(b_q) || (is_zero(a_q) && is_zero(b_q)) || (is_inf(a_q) && is_inf(b_q));
  assign inf_s = is_inf(a_q) || is_zero(b_q);
  assign dz_s  = !is_spec(a_q) && is_zero(b_q);
  assign diff  = rem_q - {1'b0, dvs_q};
  assign ge    = rem_q >= {1'b0, dvs_q};
  assign rsel  = ge ? diff : rem_q;
  // q[25] carries weight 2^0; a clear top bit means the quotient lies in [0.5,1)
  assign en    = q_q[25] ? exp_q : exp_q - 10'sd1;
  assign frac  = q_q[25] ? q_q[24:2] : q_q[23:1];
  assign ovf   = en >= 10'sd255;
  assign unf   = en <= 10'sd0;
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    pend_d   = pend_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    q_d      = q_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        busy_d  = 1'b1;
        a_d     = in1;
        b_d     = in2;
        sign_d  = in1[31] ^ in2[31];
        rem_d   = {2'b01, in1[22:0]};
        dvs_d   = {1'b1, in2[22:0]};
        exp_d   = $signed({2'b00, in1[30:23]}) - $signed({2'b00, in2[30:23]}) + 10'sd127;
        cnt_d   = 5'd0;
        q_d     = 26'd0;
        state_d = (is_spec(in1) || is_spec(in2)) ? SPEC : DIV;
      end
      SPEC: begin
        pend_d  = nan_s ? NAN_PATTERN : inf_s ? {sign_q, 31'h7F800000} : 32'h0;
        state_d = DONE;
      end
      DIV: begin
        rem_d   = rsel << 1;
        q_d     = {q_q[24:0], ge};
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == 5'(QBITS - 1)) ? NORM : DIV;
      end
      NORM: begin
        pend_d  = ovf ? {sign_q, 31'h7F800000} : unf ? 32'h0 : {sign_q, en[7:0], frac};
        state_d = DONE;
      end
      DONE: begin
        result_d = pend_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0;
      pend_q   <= 32'h0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      sign_q   <= 1'b0;
      rem_q    <= 25'h0;
      dvs_q    <= 24'h0;
      q_q      <= 26'h0;
      exp_q    <= 10'sd0;
      cnt_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      pend_q   <= pend_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      q_q      <= q_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
    end
  end
`ifdef FP_DIV_FLAGS_EN
  logic [3:0] pflg_q, pflg_d, flg_q, flg_d;
  always_comb begin
    pflg_d = pflg_q;
    flg_d  = flg_q;
    case (state_q)
      SPEC:    pflg_d = {nan_s, dz_s && !nan_s, 2'b00};
      NORM:    pflg_d = {2'b00, ovf, unf && !ovf};
      DONE:    flg_d  = pflg_q;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pflg_q <= 4'h0;
      flg_q  <= 4'h0;
    end else begin
      pflg_q <= pflg_d;
      flg_q  <= flg_d;
    end
  end
  assign flags = flg_q;
`endif
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed-vector bench for fp_div_seq with hand-computed quotients and latencies.
module tb_fp_div_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] in1 = 32'h0, in2 = 32'h0;
  logic        busy, done;
  logic [31:0] result;
`ifdef FP_DIV_FLAGS_EN
  logic [3:0]  flags;
`endif
  int          nvec = 0, nerr = 0;
  int          n;
  logic        busy_ok;
  always #5 clk = ~clk;
  fp_div_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done),
`ifdef FP_DIV_FLAGS_EN
    .flags(flags),
`endif
    .result(result)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic go(input logic [31:0] a, input logic [31:0] b);
    in1 = a;
    in2 = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  // counts edges after the accept edge until done is seen; 99 on timeout
  task automatic wait_done(output int cyc, output logic bok);
    cyc = 99;
    bok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = i;
        break;
      end
      if (!busy) bok = 1'b0;
    end
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input logic [3:0] fl);
    @(negedge clk);
    go(a, b);
    wait_done(n, busy_ok);
    chk({tag, " result"}, result, exp);
    chk({tag, " latency"}, n, lat);
    chk({tag, " busy"}, {31'b0, busy_ok}, 32'h1);
`ifdef FP_DIV_FLAGS_EN
    chk({tag, " flags"}, {28'b0, flags}, {28'b0, fl});
`else
    if (fl === 4'hF) $display("unused flag pattern");
`endif
  endtask
  initial begin
    #12;
    chk("reset result", result, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset done", {31'b0, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run("6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 28, 4'b0000);
    @(posedge clk);
    #1 chk("hold", result, 32'h40400000);
    run("1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 28, 4'b0000);
    run("5/0", 32'h40A00000, 32'h00000000, 32'h7F800000, 2, 4'b0100);
    run("-5/0", 32'hC0A00000, 32'h00000000, 32'hFF800000, 2, 4'b0100);
    run("0/0", 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 2, 4'b1000);
    run("nan/1", 32'h7FC00000, 32'h3F800000, 32'h7FFFFFFF, 2, 4'b1000);
    run("inf/inf", 32'hFF800000, 32'h7F800000, 32'h7FFFFFFF, 2, 4'b1000);
    run("0/-2", 32'h00000000, 32'hC0000000, 32'h00000000, 2, 4'b0000);
    run("ovf", 32'h7F000000, 32'h3E800000, 32'h7F800000, 28, 4'b0010);
    run("unf", 32'h00800000, 32'h40000000, 32'h00000000, 28, 4'b0001);
    run("-6/2", 32'hC0C00000, 32'h40000000, 32'hC0400000, 28, 4'b0000);
    // new operands pulsed mid-division must be ignored
    @(negedge clk);
    go(32'h40C00000, 32'h40000000);
    @(negedge clk);
    in1 = 32'h3F800000;
    in2 = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n, busy_ok);
    chk("ignore result", result, 32'h40400000);
    chk("ignore latency", n + 1, 28);
    go(32'h3F800000, 32'h40400000);
    wait_done(n, busy_ok);
    chk("b2b result", result, 32'h3EAAAAAA);
    chk("b2b latency", n, 28);
    // abort at DIV cycle 10
    @(negedge clk);
    go(32'h40C00000, 32'h40000000);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort result", result, 32'h0);
    chk("abort busy", {31'b0, busy}, 32'h0);
    busy_ok = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1 if (done) busy_ok = 1'b0;
    end
    chk("abort no done", {31'b0, busy_ok}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    run("post-reset", 32'h40C00000, 32'h40000000, 32'h40400000, 28, 4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Sequential IEEE754 single-precision divider (result = in1 / in2). It is the inverse operation of the multiplier datapath and sits beside it in the FP calculator.
- Start/busy/done handshake; radix-2 restoring mantissa division, one quotient bit per clock.
- Special operands (zero, infinity, NaN) are resolved in one state. Result encoding matches the multiplier: NaN is 32'h7FFFFFFF; zero results are 32'h00000000.

Parameters:
- QBITS, 26, quotient bits computed per division. Must be 26 for the bit selection below; any other value is illegal.
- NAN_PATTERN, 32'h7FFFFFFF, word emitted for every invalid result.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- in1  input  32  dividend, IEEE754 single
- in2  input  32  divisor, IEEE754 single
- busy  output  1  high from the accept edge until done is asserted
- done  output  1  one-cycle pulse; result is valid in the same cycle
- result  output  32  quotient; held stable until the next done

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; busy=0, done=0, result=32'h0; internal registers cleared.
  - Reset mid-operation aborts the division; no done is produced.
- Operand classification (per operand):
  - exp=255, frac!=0: NaN.
  - exp=255, frac=0: Inf.
  - exp=0: Zero. Denormals are flushed to zero.
  - Otherwise: normal.
- States: IDLE, SPEC, DIV, NORM, DONE.
- IDLE:
  - start=1 captures in1/in2, sets busy=1, computes sign = s1^s2.
  - Go to SPEC if either operand is special, else DIV.
  - start while busy is ignored; no queuing.
- SPEC (one cycle), result selection:
  - Any NaN, 0/0, Inf/Inf: NAN_PATTERN.
  - Inf/finite, or nonzero-finite/0: {sign,31'h7F800000}.
  - 0/nonzero, or finite/Inf: 32'h00000000.
  - Then go to DONE.
- DIV:
  - On entry: rem = {1'b0,1,f1} (25b), dvs = {1,f2}, exp = e1 - e2 + 127 (10-bit signed), cnt = 0.
  - Each cycle: if rem >= dvs, rem -= dvs and qbit=1, else qbit=0.
  - Then rem <<= 1, q = {q[24:0], qbit}, cnt++.
  - Leave DIV after QBITS cycles (cnt = QBITS-1 on the last cycle).
- NORM:
  - q[25] is weight 2^0.
  - If q[25]=1: frac = q[24:2], exp unchanged. Else: frac = q[23:1], exp = exp-1.
  - Rounding is truncation (toward zero).
  - exp >= 255 gives {sign,31'h7F800000}; exp <= 0 gives 32'h00000000; else {sign, exp[7:0], frac}.
- DONE: registers result, done=1 for one cycle, busy=0, then IDLE.
- start may be asserted in the cycle after done and is accepted.
- Latency, counted from the start-accept edge:
  - Special path: done high after edge 2.
  - Normal path: done high after edge QBITS+2 = 28.

Optional Feature:
- Macro FP_DIV_FLAGS_EN.
- When defined:
  - Adds output flags[3:0] = {invalid, divzero, overflow, underflow}.
  - Flags are registered together with result and held until the next done; reset value 0.
  - invalid: NaN operand, 0/0, or Inf/Inf.
  - divzero: nonzero-finite/0.
  - overflow and underflow: set on the NORM saturation paths.
- When undefined: port and logic are absent; result is unchanged.

Test Plan:
- 40C00000 / 40000000 (6/2) -> result 40400000; done exactly 28 cycles after accept; busy high throughout.
- 3F800000 / 40400000 (1/3) -> 3EAAAAAA (truncated, not 3EAAAAAB); q[25]=0 path.
- 40A00000 / 00000000 -> 7F800000; C0A00000 / 00000000 -> FF800000; 00000000 / 00000000 -> 7FFFFFFF; 7FC00000 / 3F800000 -> 7FFFFFFF. Each with done after 2 cycles; with flags enabled, divzero/invalid set accordingly.
- 7F000000 / 3E800000 -> 7F800000 (overflow); 00800000 / 40000000 -> 00000000 (underflow).
- Start pulsed during DIV with new operands -> ignored; first result correct; back-to-back start right after done -> accepted.
- rst_n low at DIV cycle 10 -> result=0, busy=0, no done. A fresh start then gives a correct result at 28 cycles.
